// File: rtl/phase_baud_generator.sv
// Fractional-rate bit-clock generator: an accumulator adds BaudRate*PHASES each cycle and
// emits a phase tick whenever it reaches ClockFreq, with SCL stretch hold and SYNC restart.
module phase_baud_generator #(
   parameter int CLK_FREQ_WIDTH = 30,
   parameter int RATE_WIDTH     = 20,
   parameter int PHASES         = 4
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         EN,
   input  logic                         SYNC,
   input  logic [CLK_FREQ_WIDTH-1:0]    ClockFreq,
   input  logic [RATE_WIDTH-1:0]        BaudRate,
   input  logic                         STRETCH,
   output logic                         CLK_OUT,
   output logic                         TICK,
   output logic [$clog2(PHASES)-1:0]    PHASE,
   output logic                         STRETCHING
);

   localparam int PW = $clog2(PHASES);
   localparam int IW = RATE_WIDTH + PW;
   localparam int SW = ((CLK_FREQ_WIDTH > IW) ? CLK_FREQ_WIDTH : IW) + 1;
   localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
   localparam logic [PW-1:0] HOLD_PHASE = PW'(PHASES / 2);

   logic [CLK_FREQ_WIDTH-1:0] acc;
   logic [CLK_FREQ_WIDTH-1:0] acc_nxt;
   logic [PW-1:0]             phase_nxt;
   logic [PW-1:0]             phase_adv;
   logic                      clk_out_nxt;
   logic                      tick_nxt;
   logic                      stretching_nxt;
   logic [IW-1:0]             inc;
   logic [SW-1:0]             freq_ext;
   logic [SW-1:0]             sum;
   logic [SW-1:0]             diff;

   // Sum and difference carry one spare bit so neither can wrap at full width.
   assign inc       = IW'(BaudRate) * IW'(PHASES);
   assign freq_ext  = SW'(ClockFreq);
   assign sum       = SW'(acc) + SW'(inc);
   assign diff      = sum - freq_ext;
   assign phase_adv = (PHASE == LAST_PHASE) ? '0 : PHASE + PW'(1);

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no branch infers a latch.
      acc_nxt        = acc;
      phase_nxt      = PHASE;
      clk_out_nxt    = CLK_OUT;
      tick_nxt       = 1'b0;
      stretching_nxt = STRETCHING;

      if (SYNC) begin
         acc_nxt        = '0;
         phase_nxt      = '0;
         clk_out_nxt    = 1'b0;
         stretching_nxt = 1'b0;
      end else if (EN && (BaudRate != '0)) begin
         if ((PHASE == HOLD_PHASE) && STRETCH) begin
            stretching_nxt = 1'b1;
         end else begin
            stretching_nxt = 1'b0;
            if (sum >= freq_ext) begin
               tick_nxt    = 1'b1;
               phase_nxt   = phase_adv;
               clk_out_nxt = (phase_adv >= HOLD_PHASE);
               // A remainder still >= ClockFreq means saturation or a lowered ClockFreq: restart at 0.
               acc_nxt     = (diff < freq_ext) ? diff[CLK_FREQ_WIDTH-1:0] : '0;
            end else begin
               acc_nxt = sum[CLK_FREQ_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc        <= '0;
         PHASE      <= '0;
         CLK_OUT    <= 1'b0;
         TICK       <= 1'b0;
         STRETCHING <= 1'b0;
      end else begin
         acc        <= acc_nxt;
         PHASE      <= phase_nxt;
         CLK_OUT    <= clk_out_nxt;
         TICK       <= tick_nxt;
         STRETCHING <= stretching_nxt;
      end
   end

endmodule

// File: tb/tb_phase_baud_generator.sv
// Self-checking bench for phase_baud_generator: directed scenarios from the rate rules plus a
// randomized run against a tick-count reference model (ticks = floor(n*inc/ClockFreq)).
module tb_phase_baud_generator;

   localparam int CFW = 30;
   localparam int RW  = 20;
   localparam int P   = 4;
   localparam int PW  = 2;

   logic           CLK = 1'b0;
   logic           RESET;
   logic           EN;
   logic           SYNC;
   logic           STRETCH;
   logic [CFW-1:0] ClockFreq;
   logic [RW-1:0]  BaudRate;
   logic           CLK_OUT;
   logic           TICK;
   logic [PW-1:0]  PHASE;
   logic           STRETCHING;

   int tests_run    = 0;
   int tests_failed = 0;

   phase_baud_generator #(
      .CLK_FREQ_WIDTH(CFW),
      .RATE_WIDTH    (RW),
      .PHASES        (P)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .EN        (EN),
      .SYNC      (SYNC),
      .ClockFreq (ClockFreq),
      .BaudRate  (BaudRate),
      .STRETCH   (STRETCH),
      .CLK_OUT   (CLK_OUT),
      .TICK      (TICK),
      .PHASE     (PHASE),
      .STRETCHING(STRETCHING)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset(input int unsigned f, input int unsigned b);
      RESET     = 1'b1;
      SYNC      = 1'b0;
      EN        = 1'b1;
      STRETCH   = 1'b0;
      ClockFreq = CFW'(f);
      BaudRate  = RW'(b);
      step();
      step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET     = 1'b1;
      SYNC      = 1'b0;
      EN        = 1'b1;
      ClockFreq = CFW'(100);
      BaudRate  = RW'(30);
      for (int k = 0; k < 4; k++) begin
         STRETCH = k[0];
         step();
         tests_run++;
         if ({CLK_OUT, TICK, PHASE, STRETCHING} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs cycle=%0d got=%b exp=00000", k, {CLK_OUT, TICK, PHASE, STRETCHING});
         end
      end
      RESET = 1'b0;
   endtask

   task automatic test_integer_ratio();
      logic [PW-1:0] exp_phase;
      do_reset(100, 5);
      for (int e = 1; e <= 20; e++) begin
         step();
         exp_phase = PW'((e / 5) % P);
         tests_run += 3;
         if (TICK !== (e % 5 == 0)) begin
            tests_failed++;
            $display("FAIL int_tick edge=%0d got=%b exp=%b", e, TICK, (e % 5 == 0));
         end
         if (PHASE !== exp_phase) begin
            tests_failed++;
            $display("FAIL int_phase edge=%0d got=%0d exp=%0d", e, PHASE, exp_phase);
         end
         if (CLK_OUT !== (exp_phase >= 2)) begin
            tests_failed++;
            $display("FAIL int_clk_out edge=%0d got=%b exp=%b", e, CLK_OUT, (exp_phase >= 2));
         end
      end
   endtask

   task automatic test_fractional();
      int last = 0, win = 0, total = 0, gap_bad = 0;
      do_reset(100, 3);
      for (int e = 1; e <= 100; e++) begin
         step();
         if (TICK === 1'b1) begin
            total++;
            win++;
            if ((e - last != 8) && (e - last != 9)) gap_bad++;
            last = e;
         end
         if (e % 25 == 0) begin
            tests_run++;
            if (win != 3) begin
               tests_failed++;
               $display("FAIL frac_window end=%0d got=%0d exp=3", e, win);
            end
            win = 0;
         end
      end
      tests_run += 2;
      if (total != 12) begin
         tests_failed++;
         $display("FAIL frac_total got=%0d exp=12", total);
      end
      if (gap_bad != 0) begin
         tests_failed++;
         $display("FAIL frac_gaps bad_gaps=%0d exp=0", gap_bad);
      end
   endtask

   task automatic test_stretch();
      do_reset(100, 5);
      for (int e = 1; e <= 10; e++) step();
      tests_run++;
      if (PHASE !== 2'd2) begin
         tests_failed++;
         $display("FAIL stretch_start_phase got=%0d exp=2", PHASE);
      end
      STRETCH = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         tests_run++;
         if ({PHASE, STRETCHING, TICK} !== {2'd2, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL stretch_hold cycle=%0d got=phase%0d/str%b/tick%b exp=phase2/str1/tick0",
                     k, PHASE, STRETCHING, TICK);
         end
      end
      STRETCH = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         tests_run += 2;
         if (TICK !== (k == 5)) begin
            tests_failed++;
            $display("FAIL stretch_release_tick cycle=%0d got=%b exp=%b", k, TICK, (k == 5));
         end
         if (STRETCHING !== 1'b0) begin
            tests_failed++;
            $display("FAIL stretch_release_flag cycle=%0d got=%b exp=0", k, STRETCHING);
         end
      end
      // Stretch outside the hold phase must be ignored.
      STRETCH = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         tests_run++;
         if ({TICK, STRETCHING} !== {(k == 5), 1'b0}) begin
            tests_failed++;
            $display("FAIL stretch_ignored cycle=%0d got=tick%b/str%b exp=tick%b/str0",
                     k, TICK, STRETCHING, (k == 5));
         end
      end
      STRETCH = 1'b0;
   endtask

   task automatic test_en_sync();
      do_reset(100, 5);
      for (int e = 1; e <= 7; e++) step();
      EN = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         tests_run++;
         if ({TICK, PHASE} !== {1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL en_freeze cycle=%0d got=tick%b/phase%0d exp=tick0/phase1", k, TICK, PHASE);
         end
      end
      EN = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         tests_run++;
         if (TICK !== (k == 3)) begin
            tests_failed++;
            $display("FAIL en_resume cycle=%0d got=%b exp=%b", k, TICK, (k == 3));
         end
      end
      for (int k = 1; k <= 4; k++) step();
      tests_run++;
      if ({PHASE, CLK_OUT} !== {2'd2, 1'b1}) begin
         tests_failed++;
         $display("FAIL sync_pre got=phase%0d/clk%b exp=phase2/clk1", PHASE, CLK_OUT);
      end
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
      tests_run++;
      if ({PHASE, CLK_OUT, TICK} !== {2'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL sync_clear got=phase%0d/clk%b/tick%b exp=phase0/clk0/tick0", PHASE, CLK_OUT, TICK);
      end
      for (int k = 1; k <= 5; k++) begin
         step();
         tests_run++;
         if (TICK !== (k == 5)) begin
            tests_failed++;
            $display("FAIL sync_next_tick cycle=%0d got=%b exp=%b", k, TICK, (k == 5));
         end
      end
   endtask

   task automatic test_boundary();
      do_reset(100, 5);
      for (int e = 1; e <= 7; e++) step();
      BaudRate = '0;
      for (int k = 1; k <= 10; k++) begin
         step();
         tests_run++;
         if ({TICK, PHASE, CLK_OUT} !== {1'b0, 2'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL idle_hold cycle=%0d got=tick%b/phase%0d/clk%b exp=tick0/phase1/clk0",
                     k, TICK, PHASE, CLK_OUT);
         end
      end
      BaudRate = RW'(5);
      for (int k = 1; k <= 3; k++) begin
         step();
         tests_run++;
         if (TICK !== (k == 3)) begin
            tests_failed++;
            $display("FAIL idle_resume cycle=%0d got=%b exp=%b", k, TICK, (k == 3));
         end
      end

      do_reset(100, 30);
      for (int k = 1; k <= 8; k++) begin
         step();
         tests_run++;
         if ({TICK, PHASE} !== {1'b1, PW'(k % P)}) begin
            tests_failed++;
            $display("FAIL saturate cycle=%0d got=tick%b/phase%0d exp=tick1/phase%0d", k, TICK, PHASE, k % P);
         end
      end

      do_reset(0, 5);
      for (int k = 1; k <= 4; k++) begin
         step();
         tests_run++;
         if (TICK !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_freq cycle=%0d got=%b exp=1", k, TICK);
         end
      end

      do_reset(100, 5);
      for (int e = 1; e <= 3; e++) step();
      ClockFreq = CFW'(10);
      step();
      tests_run++;
      if ({TICK, PHASE} !== {1'b1, 2'd1}) begin
         tests_failed++;
         $display("FAIL lower_freq got=tick%b/phase%0d exp=tick1/phase1", TICK, PHASE);
      end
      ClockFreq = CFW'(100);
      for (int k = 1; k <= 5; k++) begin
         step();
         tests_run++;
         if (TICK !== (k == 5)) begin
            tests_failed++;
            $display("FAIL lower_freq_acc_cleared cycle=%0d got=%b exp=%b", k, TICK, (k == 5));
         end
      end
   endtask

   task automatic test_full_width();
      int last = 0, total = 0, gap_bad = 0;
      do_reset(50000000, 400000);
      for (int e = 1; e <= 2000; e++) begin
         step();
         if (TICK === 1'b1) begin
            total++;
            if ((e - last != 31) && (e - last != 32)) gap_bad++;
            last = e;
         end
      end
      tests_run += 2;
      if (total != 64) begin
         tests_failed++;
         $display("FAIL full_width_count got=%0d exp=64", total);
      end
      if (gap_bad != 0) begin
         tests_failed++;
         $display("FAIL full_width_gaps bad_gaps=%0d exp=0", gap_bad);
      end
   endtask

   // Reference: with fixed inc<f, after n accumulating cycles the tick count is floor(n*inc/f).
   task automatic test_random();
      longint unsigned n, inc, f, b;
      int   m_phase;
      logic m_clk, m_tick, m_str;
      do_reset(100, 5);
      n = 0; m_phase = 0; m_clk = 1'b0; m_tick = 1'b0; m_str = 1'b0;
      for (int seg = 0; seg < 10; seg++) begin
         f = longint'($urandom_range(1, 3000));
         b = longint'($urandom_range(1, int'(f / 3) + 1));
         ClockFreq = CFW'(f);
         for (int c = 0; c < 200; c++) begin
            SYNC     = (c == 0) || ($urandom_range(0, 49) == 0);
            EN       = ($urandom_range(0, 9) != 0);
            STRETCH  = ($urandom_range(0, 2) == 0);
            BaudRate = ($urandom_range(0, 19) == 0) ? '0 : RW'(b);
            step();
            m_tick = 1'b0;
            if (SYNC) begin
               n = 0; m_phase = 0; m_clk = 1'b0; m_str = 1'b0;
            end else if (EN && BaudRate != '0) begin
               if (m_phase == P / 2 && STRETCH) begin
                  m_str = 1'b1;
               end else begin
                  m_str = 1'b0;
                  inc = b * P;
                  if (inc >= f) begin
                     m_tick = 1'b1;
                  end else begin
                     n++;
                     m_tick = ((n * inc) / f) != (((n - 1) * inc) / f);
                  end
                  if (m_tick) begin
                     m_phase = (m_phase + 1) % P;
                     m_clk   = (m_phase >= P / 2);
                  end
               end
            end
            tests_run++;
            if ({TICK, PHASE, CLK_OUT, STRETCHING} !== {m_tick, PW'(m_phase), m_clk, m_str}) begin
               tests_failed++;
               $display("FAIL random seg=%0d cyc=%0d f=%0d b=%0d got=tick%b/phase%0d/clk%b/str%b exp=tick%b/phase%0d/clk%b/str%b",
                        seg, c, f, b, TICK, PHASE, CLK_OUT, STRETCHING, m_tick, m_phase, m_clk, m_str);
            end
         end
      end
      SYNC    = 1'b0;
      STRETCH = 1'b0;
      EN      = 1'b1;
   endtask

   initial begin
      RESET     = 1'b1;
      EN        = 1'b0;
      SYNC      = 1'b0;
      STRETCH   = 1'b0;
      ClockFreq = '0;
      BaudRate  = '0;
      test_reset();
      test_integer_ratio();
      test_fractional();
      test_stretch();
      test_en_sync();
      test_boundary();
      test_full_width();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
